// File: rtl/ofm_tile_collector_pkg.sv
// Shared definitions for the OFM tile collector and its transpose buffer.
package ofm_tile_collector_pkg;

    localparam int DEF_SYSTOLIC_SIZE = 16;
    localparam int DEF_DATA_WIDTH    = 16;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_REQ,
        ST_DRAIN,
        ST_GAP
    } state_t;

    function automatic int word_width(input int n, input int dw);
        return n * dw;
    endfunction

endpackage

// File: rtl/ofm_tile_collector_transpose_buf.sv
// Pixel-row write, channel-column read storage for one output tile.
module ofm_transpose_buf
    import ofm_tile_collector_pkg::*;
#(
    parameter int N  = DEF_SYSTOLIC_SIZE,
    parameter int DW = DEF_DATA_WIDTH,
    parameter int WW = word_width(N, DW),
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [IW-1:0] i_row,
    input  logic          i_pad,
    input  logic [WW-1:0] i_data,
    input  logic [IW-1:0] i_col,
    output logic [WW-1:0] o_word
);

    logic [N-1:0][WW-1:0] r_mem;

    // The last beat of a layer clears every row above it so a short tail
    // never leaks pixels from the previous tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (i_we) begin
            for (int p = 0; p < N; p++) begin
                if (IW'(p) == i_row) begin
                    r_mem[p] <= i_data;
                end else if (i_pad && (IW'(p) > i_row)) begin
                    r_mem[p] <= '0;
                end
            end
        end
    end

    always_comb begin
        o_word = '0;
        for (int p = 0; p < N; p++) begin
            o_word[p*DW +: DW] = r_mem[p][i_col*DW +: DW];
        end
    end

endmodule

// File: rtl/ofm_tile_collector.sv
// Collects systolic pixel beats, transposes them, and drains channel
// words in step with the OFM address controller's addr_valid.
module ofm_tile_collector
    import ofm_tile_collector_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int WORD_WIDTH    = word_width(SYSTOLIC_SIZE, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  write,
    input  logic                  addr_valid,
    output logic [WORD_WIDTH-1:0] ofm_data,
    output logic                  ofm_we,
    output logic                  tile_done,
    output logic                  layer_done
);

    localparam int            CW   = $clog2(SYSTOLIC_SIZE);
    localparam logic [CW-1:0] LAST = CW'(SYSTOLIC_SIZE - 1);

    state_t          r_state;
    logic [CW-1:0]   r_pix_cnt;
    logic [CW-1:0]   r_ch_cnt;
    logic            r_last_flag;
    logic            r_in_ready;
    logic            r_write;
    logic            r_tile_done;
    logic            r_layer_done;
    logic            w_accept;
    logic            w_drain_beat;
    logic [WORD_WIDTH-1:0] w_col_word;

    assign w_accept     = in_valid && r_in_ready && (r_state == ST_FILL);
    assign w_drain_beat = addr_valid && (r_state == ST_DRAIN);

    ofm_transpose_buf #(
        .N  (SYSTOLIC_SIZE),
        .DW (DATA_WIDTH),
        .WW (WORD_WIDTH),
        .IW (CW)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_accept),
        .i_row  (r_pix_cnt),
        .i_pad  (in_last),
        .i_data (in_data),
        .i_col  (r_ch_cnt),
        .o_word (w_col_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_pix_cnt    <= '0;
            r_ch_cnt     <= '0;
            r_last_flag  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_write      <= 1'b0;
            r_tile_done  <= 1'b0;
            r_layer_done <= 1'b0;
        end else begin
            r_write      <= 1'b0;
            r_tile_done  <= 1'b0;
            r_layer_done <= 1'b0;
            unique case (r_state)
                ST_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_pix_cnt   <= r_pix_cnt + 1'b1;
                        r_last_flag <= in_last;
                        if (r_pix_cnt == LAST || in_last) begin
                            r_state    <= ST_REQ;
                            r_write    <= 1'b1;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    r_pix_cnt <= '0;
                    r_state   <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (addr_valid) begin
                        if (r_ch_cnt == LAST) begin
                            r_ch_cnt     <= '0;
                            r_tile_done  <= 1'b1;
                            r_layer_done <= r_last_flag;
                            r_state      <= ST_GAP;
                        end else begin
                            r_ch_cnt <= r_ch_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    r_last_flag <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_FILL;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign write      = r_write;
    assign tile_done  = r_tile_done;
    assign layer_done = r_layer_done;
    assign ofm_we     = w_drain_beat;
    assign ofm_data   = w_col_word;

endmodule

// File: tb/tb_ofm_tile_collector.sv
// Directed self-checking bench for ofm_tile_collector.
module tb_ofm_tile_collector;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int WW = N * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          write;
    logic          addr_valid = 1'b0;
    logic [WW-1:0] ofm_data;
    logic          ofm_we;
    logic          tile_done;
    logic          layer_done;

    int checks = 0;
    int failures = 0;
    int n_writes = 0;
    int n_tdone = 0;
    int cyc = 0;
    int last_av = -100;
    int wr_gap = 0;

    ofm_tile_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .write      (write),
        .addr_valid (addr_valid),
        .ofm_data   (ofm_data),
        .ofm_we     (ofm_we),
        .tile_done  (tile_done),
        .layer_done (layer_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (write) begin
            n_writes = n_writes + 1;
            wr_gap = cyc - last_av;
        end
        if (tile_done) n_tdone = n_tdone + 1;
        if (addr_valid && ofm_we) last_av = cyc;
    end

    typedef struct {
        int          nbeats;
        logic [15:0] base;
        bit          last;
        int          stall_at;
        int          stall_len;
        bit          exp_layer;
    } vec_t;

    task automatic chk(input string nm, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] beat(input logic [15:0] base, input int p);
        logic [WW-1:0] w;
        for (int c = 0; c < N; c++) w[c*DW +: DW] = base + 16'(p*16 + c);
        return w;
    endfunction

    function automatic logic [WW-1:0] col(input logic [15:0] base, input int nb,
                                          input int ch);
        logic [WW-1:0] w;
        for (int p = 0; p < N; p++)
            w[p*DW +: DW] = (p < nb) ? base + 16'(p*16 + ch) : 16'h0;
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [WW-1:0] d, input logic l);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        k = 0;
        while (!in_ready && k < 80) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("beat_accept", WW'(in_ready), WW'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic fill(input logic [15:0] base, input int nb, input bit last);
        for (int p = 0; p < nb; p++) send_beat(beat(base, p), last && (p == nb - 1));
    endtask

    task automatic drain(input vec_t v, input string tag);
        bit stalled;
        stalled = 1'b0;
        #1;
        chk({tag, "_write_req"}, WW'(write), WW'(1));
        chk({tag, "_ready_req"}, WW'(in_ready), WW'(0));
        @(negedge clk);
        #1;
        chk({tag, "_write_once"}, WW'(write), WW'(0));
        for (int ch = 0; ch < N; ch++) begin
            if (v.stall_len > 0 && ch == v.stall_at && !stalled) begin
                addr_valid = 1'b0;
                stalled = 1'b1;
                for (int s = 0; s < v.stall_len; s++) begin
                    #1;
                    chk({tag, "_we_stall"}, WW'(ofm_we), WW'(0));
                    @(negedge clk);
                end
            end
            addr_valid = 1'b1;
            #1;
            chk({tag, "_we"}, WW'(ofm_we), WW'(1));
            chk({tag, "_ready_drain"}, WW'(in_ready), WW'(0));
            chk({tag, $sformatf("_ch%0d", ch)}, ofm_data, col(v.base, v.nbeats, ch));
            @(negedge clk);
        end
        addr_valid = 1'b0;
        #1;
        chk({tag, "_tile_done"}, WW'(tile_done), WW'(1));
        chk({tag, "_layer_done"}, WW'(layer_done), WW'(v.exp_layer));
        chk({tag, "_ready_gap"}, WW'(in_ready), WW'(0));
        @(negedge clk);
        #1;
        chk({tag, "_tile_done_off"}, WW'(tile_done), WW'(0));
        chk({tag, "_ready_fill"}, WW'(in_ready), WW'(1));
    endtask

    vec_t vecs[4];
    vec_t v;

    initial begin
        vecs[0] = '{nbeats: 16, base: 16'h0000, last: 0, stall_at: 16, stall_len: 0, exp_layer: 0};
        vecs[1] = '{nbeats: 4,  base: 16'hA000, last: 1, stall_at: 16, stall_len: 0, exp_layer: 1};
        vecs[2] = '{nbeats: 16, base: 16'h1000, last: 0, stall_at: 5,  stall_len: 3, exp_layer: 0};
        vecs[3] = '{nbeats: 16, base: 16'h2000, last: 1, stall_at: 16, stall_len: 0, exp_layer: 1};

        #12;
        chk("rst_in_ready", WW'(in_ready), WW'(0));
        chk("rst_write", WW'(write), WW'(0));
        chk("rst_ofm_we", WW'(ofm_we), WW'(0));
        chk("rst_ofm_data", ofm_data, '0);
        chk("rst_done", WW'({tile_done, layer_done}), WW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            fill(vecs[i].base, vecs[i].nbeats, vecs[i].last);
            drain(vecs[i], $sformatf("vec%0d", i));
        end

        // Spurious addr_valid while filling must not move the channel counter.
        v = '{nbeats: 16, base: 16'h5000, last: 0, stall_at: 16, stall_len: 0, exp_layer: 0};
        for (int p = 0; p < 8; p++) send_beat(beat(v.base, p), 1'b0);
        addr_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("spur_we", WW'(ofm_we), WW'(0));
            chk("spur_tile_done", WW'(tile_done), WW'(0));
            @(negedge clk);
        end
        addr_valid = 1'b0;
        for (int p = 8; p < 16; p++) send_beat(beat(v.base, p), 1'b0);
        drain(v, "spur");

        // Back-to-back: in_valid held high with tile B's first beat across A's drain.
        v = '{nbeats: 16, base: 16'h6000, last: 0, stall_at: 16, stall_len: 0, exp_layer: 0};
        fill(v.base, 16, 1'b0);
        in_valid = 1'b1;
        in_data  = beat(16'h7000, 0);
        drain(v, "b2b_a");
        v.base = 16'h7000;
        fill(v.base, 16, 1'b0);
        drain(v, "b2b_b");
        checks++;
        if (wr_gap < 2) begin
            failures++;
            $display("FAIL b2b_write_gap actual=%0d required>=2", wr_gap);
        end

        // Reset in the middle of a drain.
        fill(16'h3000, 16, 1'b0);
        @(negedge clk);
        for (int ch = 0; ch < 7; ch++) begin
            addr_valid = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", WW'(ofm_we), WW'(0));
        chk("mid_rst_data", ofm_data, '0);
        chk("mid_rst_ctrl", WW'({in_ready, write, tile_done, layer_done}), WW'(0));
        @(negedge clk);
        addr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        v = '{nbeats: 16, base: 16'h4000, last: 0, stall_at: 16, stall_len: 0, exp_layer: 0};
        fill(v.base, 16, 1'b0);
        drain(v, "post_rst");

        chk("total_writes", WW'(n_writes), WW'(9));
        chk("total_tile_done", WW'(n_tdone), WW'(8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ofm_tile_collector.md
Name: ofm_tile_collector

Overview:
- Sits between the systolic array output and the OFM address controller.
- Collects SYSTOLIC_SIZE pixel beats, each holding SYSTOLIC_SIZE channel results, and transposes them into per-channel 16-pixel words.
- Pulses `write` to start the address controller's channel sweep.
- Presents one channel word on every cycle the controller's addr_valid is high, so memory sees address and data together.

Parameters:
- SYSTOLIC_SIZE, 16, channels per beat, and pixels per output word.
- DATA_WIDTH, 16, width of one result element.
- WORD_WIDTH, SYSTOLIC_SIZE*DATA_WIDTH, derived width of a beat and of an output word.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  systolic array presents a pixel beat
- in_ready  out  1  collector can accept a beat
- in_data  in  WORD_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  1  final beat of the layer; qualified by in_valid
- write  out  1  one-cycle start pulse to the OFM address controller
- addr_valid  in  1  address controller's per-channel valid
- ofm_data  out  WORD_WIDTH  channel word; pixel p at [p*DATA_WIDTH +: DATA_WIDTH]
- ofm_we  out  1  memory write enable (= addr_valid while in DRAIN)
- tile_done  out  1  one-cycle pulse after 16th channel drained
- layer_done  out  1  one-cycle pulse with tile_done of the in_last tile

Behaviour:
- Reset: all outputs 0; buffer zeroed; pix_cnt=ch_cnt=0; state FILL; last_flag=0. Reset mid-drain aborts the tile; no partial state survives.
- Storage: buffer[p][c], SYSTOLIC_SIZE x SYSTOLIC_SIZE x DATA_WIDTH. A single bank; no double buffering.
- FILL state:
  - in_ready=1.
  - On in_valid&in_ready: buffer[pix_cnt][*] <= in_data; pix_cnt++; last_flag <= in_last.
  - Go to REQ when pix_cnt reaches SYSTOLIC_SIZE-1 on an accepted beat, or when in_last is accepted.
  - Partial tile: pixels pix_cnt+1..15 are written with 0 on the in_last beat. The layer tail of 414*414 mod 16 = 4 pixels yields a 12-pixel zero pad.
- REQ state (one cycle):
  - write=1 (registered output, high exactly this cycle); in_ready=0; pix_cnt <= 0.
  - Go to DRAIN.
- DRAIN state:
  - in_ready=0; in_valid is ignored and not consumed.
  - ofm_data = buffer[*][ch_cnt] (combinational transpose mux), ofm_we = addr_valid.
  - Each addr_valid cycle: ch_cnt++.
  - On the addr_valid cycle where ch_cnt==SYSTOLIC_SIZE-1: ch_cnt <= 0; tile_done=1 next cycle; layer_done=1 next cycle if last_flag; go to GAP.
  - addr_valid gaps inside DRAIN are tolerated; ch_cnt holds.
- GAP state (one cycle):
  - in_ready=0; clear last_flag; go to FILL.
  - Guarantees the next write lands no earlier than 2 cycles after the last addr_valid, while the controller is back in its idle state.
- Sequencing against the address controller: write sampled at edge N -> addr_valid high for cycles N+1..N+16 with channel addresses 0..15. The collector does not count cycles; it only follows addr_valid.
- addr_valid outside DRAIN: ignored; ofm_we=0; ofm_data don't-care (drive buffer[*][0]).
- ofm_data is stable whenever ofm_we=1.
- in_last on a full 16th beat: normal tile, layer_done asserted.
- Throughput: 16 fill + 1 REQ + ≥16 DRAIN + 1 GAP cycles per tile.

Decomposition:
- Shared package holds:
  - SYSTOLIC_SIZE and DATA_WIDTH defaults.
  - State encoding: FILL, REQ, DRAIN, GAP.
  - WORD_WIDTH helper.
- One natural sub-module, `ofm_transpose_buf`:
  - Write port is one row per beat with zero-pad mask.
  - Read port is a combinational column select.
  - The FSM/counters remain in the top.

Test Plan:
- 16 beats, beat p channel c = p*16+c; addr_valid for 16 consecutive cycles after write -> `write` pulse once, 1 cycle after 16th beat; ofm_data on channel-3 cycle = {pixel p = p*16+3} for p=0..15; tile_done once.
- Back-to-back tiles with continuous in_valid -> in_ready low from REQ through GAP; no beat dropped or duplicated; second write ≥2 cycles after last addr_valid of tile 1.
- in_last on beat 4 (pixels 0..3 = 0xA000+p) -> write after beat 4; each channel word has pixels 4..15 = 0; layer_done and tile_done coincide.
- addr_valid stalled: high 5 cycles, low 3, high 11 -> ch_cnt holds during low; ofm_we=0 during low; all 16 channels emitted exactly once in order.
- Spurious addr_valid during FILL -> ofm_we stays 0, ch_cnt unchanged, no tile_done.
- rst_n asserted mid-DRAIN at channel 7 -> outputs 0 immediately; after release a fresh 16-beat tile drains channels 0..15 with no stale data.
